uart_mmio_ctrl: RTL and testbench

Memory-mapped UART controller between the core's memory-control decoder and the UART. It replaces the loose tx-start/tx-data/rx-ready/rx-data/clean-rx registers with one register window backed by TX and RX FIFOs. Two independent FSMs sequence the UART:

- the TX FSM performs the start/busy handshake;
- the RX FSM captures received bytes and issues clear-rx.

Runs on the core clock.

---
 rtl/uart_mmio_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: a four-register window over TX/RX byte FIFOs,
// with independent FSMs running the UART start/busy and ready/clear handshakes.

module uart_mmio_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  // A full FIFO rejects a push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only
  // observable after being written, and a reset would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module uart_mmio_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel_i,
  input  logic [1:0]            addr_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  uart_tx_start_o,
  output logic [7:0]            uart_tx_data_o,
  input  logic                  uart_tx_busy_i,
  input  logic [7:0]            uart_rx_data_i,
  input  logic                  uart_rx_ready_i,
  output logic                  uart_clear_rx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_WAIT  = 2'd2;
  localparam logic [0:0] RX_IDLE  = 1'b0;
  localparam logic [0:0] RX_CLEAR = 1'b1;

  logic [1:0]  tx_state;
  logic [0:0]  rx_state;
  logic        overrun;

  logic        wr_en, rd_en;
  logic        tx_flush, rx_flush, ovr_clr;
  logic        tx_push, tx_pop, rx_take, rx_drop, rx_pop;
  logic [7:0]  tx_head, rx_head;
  logic [AW:0] tx_count, rx_count;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_idle;
  logic [23:0] status;
  logic        wdata_unused;

  assign wr_en    = sel_i & we_i;
  assign rd_en    = sel_i & re_i;
  assign tx_flush = wr_en & (addr_i == 2'd3) & wdata_i[0];
  assign rx_flush = wr_en & (addr_i == 2'd3) & wdata_i[1];
  assign ovr_clr  = wr_en & (addr_i == 2'd3) & wdata_i[2];
  assign tx_push  = wr_en & (addr_i == 2'd0);
  assign rx_pop   = rd_en & (addr_i == 2'd1);
  // A flush in the same cycle suppresses the FSM's pop, so nothing starts.
  assign tx_pop   = (tx_state == TX_IDLE) & ~tx_empty & ~tx_flush;
  assign rx_take  = (rx_state == RX_IDLE) & uart_rx_ready_i;
  assign rx_drop  = rx_take & rx_full;
  assign wdata_unused = ^wdata_i[DATA_WIDTH-1:8];

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .wdata(wdata_i[7:0]), .head(tx_head), .count(tx_count),
    .full(tx_full), .empty(tx_empty)
  );

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_take), .pop(rx_pop), .flush(rx_flush),
    .wdata(uart_rx_data_i), .head(rx_head), .count(rx_count),
    .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state        <= TX_IDLE;
      uart_tx_start_o <= 1'b0;
      uart_tx_data_o  <= 8'h00;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          uart_tx_data_o  <= tx_head;
          uart_tx_start_o <= 1'b1;
          tx_state        <= TX_START;
        end
        TX_START: if (uart_tx_busy_i) begin
          uart_tx_start_o <= 1'b0;
          tx_state        <= TX_WAIT;
        end
        TX_WAIT: if (!uart_tx_busy_i) tx_state <= TX_IDLE;
        default: begin
          uart_tx_start_o <= 1'b0;
          tx_state        <= TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state        <= RX_IDLE;
      uart_clear_rx_o <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: if (uart_rx_ready_i) begin
          uart_clear_rx_o <= 1'b1;
          rx_state        <= RX_CLEAR;
        end
        default: if (!uart_rx_ready_i) begin
          uart_clear_rx_o <= 1'b0;
          rx_state        <= RX_IDLE;
        end
      endcase
    end
  end

  // A dropped byte outranks a software clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)        overrun <= 1'b0;
    else if (rx_drop) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

  assign tx_idle = tx_empty & (tx_state == TX_IDLE);
  assign status  = {8'(tx_count), 8'(rx_count), 3'b000,
                    overrun, tx_idle, tx_full, rx_full, ~rx_empty};

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      2'd1:    if (!rx_empty) rdata_o = DATA_WIDTH'(rx_head);
      2'd2:    rdata_o = DATA_WIDTH'(status);
      default: rdata_o = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: directed scenarios plus a randomized
// register/UART sequence scored against a queue-based model.

module tb_uart_mmio_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel_i, we_i, re_i;
  logic [1:0]    addr_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o;
  logic          uart_tx_start_o;
  logic [7:0]    uart_tx_data_o;
  logic          uart_tx_busy_i;
  logic [7:0]    uart_rx_data_i;
  logic          uart_rx_ready_i;
  logic          uart_clear_rx_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  uart_mmio_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sel_i(sel_i), .addr_i(addr_i), .we_i(we_i),
    .re_i(re_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .uart_tx_start_o(uart_tx_start_o), .uart_tx_data_o(uart_tx_data_o),
    .uart_tx_busy_i(uart_tx_busy_i), .uart_rx_data_i(uart_rx_data_i),
    .uart_rx_ready_i(uart_rx_ready_i), .uart_clear_rx_o(uart_clear_rx_o)
  );

  always #5 clk = ~clk;

  // Expected STATUS word from model-level counts and flags.
  function automatic logic [31:0] exp_status(int txc, int rxc, bit ovr, bit txidle);
    return {8'h00, 8'(txc), 8'(rxc), 3'b000, ovr, txidle,
            (txc == DEPTH), (rxc == DEPTH), (rxc != 0)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel_i = 1; we_i = 1; addr_i = a; wdata_i = d;
    @(posedge clk); #1;
    sel_i = 0; we_i = 0; wdata_i = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel_i = 1; re_i = 1; addr_i = a;
    #1 d = rdata_o;
    @(posedge clk); #1;
    sel_i = 0; re_i = 0;
  endtask

  task automatic peek_status(output logic [31:0] s);
    addr_i = 2'd2;
    #1 s = rdata_o;
  endtask

  // One UART receive: ready for one cycle, then the clear handshake completes.
  task automatic inject_rx(input logic [7:0] b, output bit ok);
    bit hi;
    uart_rx_data_i = b; uart_rx_ready_i = 1;
    @(posedge clk); #1;
    hi = uart_clear_rx_o;
    uart_rx_ready_i = 0;
    @(posedge clk); #1;
    ok = hi && !uart_clear_rx_o;
  endtask

  task automatic test_reset();
    logic [31:0] s;
    reset = 1; sel_i = 0; we_i = 0; re_i = 0; addr_i = 0; wdata_i = 0;
    uart_tx_busy_i = 0; uart_rx_data_i = 0; uart_rx_ready_i = 0;
    cycles(3);
    reset = 0;
    peek_status(s);
    chk_cnt++; if (s !== 32'h8) $display("FAIL reset_status: got %h expected %h", s, 32'h8); else pass_cnt++;
    chk_cnt++;
    if ({uart_tx_start_o, uart_tx_data_o, uart_clear_rx_o} !== 10'h0)
      $display("FAIL reset_outputs: got start=%b data=%h clear=%b expected all 0",
               uart_tx_start_o, uart_tx_data_o, uart_clear_rx_o);
    else pass_cnt++;
  endtask

  task automatic test_tx_pair();
    logic [31:0] s;
    logic [7:0]  seen[$];
    int delay = 0, busy_left = 0;
    bus_write(0, 32'h41);
    chk_cnt++; if (uart_tx_start_o !== 1'b0) $display("FAIL tx_latency_early: got start=%b expected 0", uart_tx_start_o); else pass_cnt++;
    peek_status(s);
    chk_cnt++; if (s !== exp_status(1, 0, 0, 0)) $display("FAIL tx_count_one: got %h expected %h", s, exp_status(1, 0, 0, 0)); else pass_cnt++;
    bus_write(0, 32'h42);
    chk_cnt++;
    if (uart_tx_start_o !== 1'b1 || uart_tx_data_o !== 8'h41)
      $display("FAIL tx_latency: got start=%b data=%h expected 1/41", uart_tx_start_o, uart_tx_data_o);
    else pass_cnt++;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) uart_tx_busy_i = 0;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin uart_tx_busy_i = 1; busy_left = 10; end
      end else if (uart_tx_start_o && !uart_tx_busy_i) begin
        seen.push_back(uart_tx_data_o);
        delay = 2;
      end
    end
    chk_cnt++;
    if (seen.size() != 2) $display("FAIL tx_pair_starts: got %0d expected 2", seen.size());
    else if (seen[0] !== 8'h41 || seen[1] !== 8'h42)
      $display("FAIL tx_pair_data: got %h,%h expected 41,42", seen[0], seen[1]);
    else pass_cnt++;
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 0, 0, 1)) $display("FAIL tx_pair_idle: got %h expected %h", s, exp_status(0, 0, 0, 1)); else pass_cnt++;
    chk_cnt++; if (uart_tx_data_o !== 8'h42) $display("FAIL tx_data_hold: got %h expected 42", uart_tx_data_o); else pass_cnt++;
  endtask

  task automatic test_tx_full();
    logic [31:0] s;
    uart_tx_busy_i = 1;
    for (int i = 0; i < 9; i++) bus_write(0, 32'h60 + i);
    peek_status(s);
    chk_cnt++; if (s !== exp_status(8, 0, 0, 0)) $display("FAIL tx_full_set: got %h expected %h", s, exp_status(8, 0, 0, 0)); else pass_cnt++;
    bus_write(0, 32'h7F);
    peek_status(s);
    chk_cnt++; if (s !== exp_status(8, 0, 0, 0)) $display("FAIL tx_full_ignore: got %h expected %h", s, exp_status(8, 0, 0, 0)); else pass_cnt++;
    chk_cnt++;
    if (uart_tx_start_o !== 1'b0 || uart_tx_data_o !== 8'h60)
      $display("FAIL tx_full_inflight: got start=%b data=%h expected 0/60", uart_tx_start_o, uart_tx_data_o);
    else pass_cnt++;
    bus_write(3, 32'h1);
    uart_tx_busy_i = 0;
    cycles(3);
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 0, 0, 1) || uart_tx_start_o !== 1'b0) $display("FAIL tx_full_drain: got %h start=%b expected %h start=0", s, uart_tx_start_o, exp_status(0, 0, 0, 1)); else pass_cnt++;
  endtask

  task automatic test_rx_single();
    logic [31:0] s, d;
    uart_rx_data_i = 8'h55; uart_rx_ready_i = 1;
    @(posedge clk); #1;
    chk_cnt++; if (uart_clear_rx_o !== 1'b1) $display("FAIL rx_clear_rise: got %b expected 1", uart_clear_rx_o); else pass_cnt++;
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 1, 0, 1)) $display("FAIL rx_push: got %h expected %h", s, exp_status(0, 1, 0, 1)); else pass_cnt++;
    cycles(3);
    peek_status(s);
    chk_cnt++; if (uart_clear_rx_o !== 1'b1 || s !== exp_status(0, 1, 0, 1)) $display("FAIL rx_clear_hold: got clear=%b status=%h expected 1/%h", uart_clear_rx_o, s, exp_status(0, 1, 0, 1)); else pass_cnt++;
    uart_rx_ready_i = 0;
    @(posedge clk); #1;
    chk_cnt++; if (uart_clear_rx_o !== 1'b0) $display("FAIL rx_clear_fall: got %b expected 0", uart_clear_rx_o); else pass_cnt++;
    bus_read(1, d);
    chk_cnt++; if (d !== 32'h55) $display("FAIL rx_read: got %h expected 00000055", d); else pass_cnt++;
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 0, 0, 1)) $display("FAIL rx_after_pop: got %h expected %h", s, exp_status(0, 0, 0, 1)); else pass_cnt++;
    bus_read(1, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL rx_read_empty: got %h expected 0", d); else pass_cnt++;
  endtask

  task automatic test_rx_overrun();
    logic [31:0] s, d;
    bit ok;
    int pulses = 0;
    for (int i = 0; i < 9; i++) begin
      inject_rx(8'hA0 + 8'(i), ok);
      if (ok) pulses++;
    end
    chk_cnt++; if (pulses != 9) $display("FAIL rx_clear_pulses: got %0d expected 9", pulses); else pass_cnt++;
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 8, 1, 1)) $display("FAIL rx_overrun: got %h expected %h", s, exp_status(0, 8, 1, 1)); else pass_cnt++;
    bus_write(3, 32'h4);
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 8, 0, 1)) $display("FAIL ovr_clear: got %h expected %h", s, exp_status(0, 8, 0, 1)); else pass_cnt++;
    bus_read(1, d);
    chk_cnt++; if (d !== 32'hA0) $display("FAIL rx_full_order: got %h expected 000000a0", d); else pass_cnt++;
    bus_write(3, 32'h2);
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 0, 0, 1)) $display("FAIL rx_flush: got %h expected %h", s, exp_status(0, 0, 0, 1)); else pass_cnt++;
  endtask

  task automatic test_back_to_back_rx();
    logic [31:0] s, d;
    bit ok;
    logic [7:0] exp_b;
    for (int i = 0; i < 3; i++) inject_rx(8'h31 + 8'(i), ok);
    uart_rx_data_i = 8'h34; uart_rx_ready_i = 1;
    sel_i = 1; re_i = 1; addr_i = 2'd1;
    #1 d = rdata_o;
    @(posedge clk); #1;
    sel_i = 0; re_i = 0; uart_rx_ready_i = 0;
    chk_cnt++; if (d !== 32'h31) $display("FAIL popush_data: got %h expected 00000031", d); else pass_cnt++;
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 3, 0, 1)) $display("FAIL popush_count: got %h expected %h", s, exp_status(0, 3, 0, 1)); else pass_cnt++;
    cycles(1);
    for (int i = 0; i < 3; i++) begin
      exp_b = 8'h32 + 8'(i);
      bus_read(1, d);
      chk_cnt++; if (d !== 32'(exp_b)) $display("FAIL popush_order%0d: got %h expected %h", i, d, exp_b); else pass_cnt++;
    end
  endtask

  task automatic test_tx_flush();
    logic [31:0] s;
    bit started = 0;
    uart_tx_busy_i = 0;
    bus_write(0, 32'h11);
    bus_write(0, 32'h22);
    bus_write(0, 32'h33);
    uart_tx_busy_i = 1;
    cycles(1);
    bus_write(3, 32'h1);
    peek_status(s);
    chk_cnt++; if (s !== exp_status(0, 0, 0, 0)) $display("FAIL txflush_wait: got %h expected %h", s, exp_status(0, 0, 0, 0)); else pass_cnt++;
    uart_tx_busy_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (uart_tx_start_o) started = 1;
    end
    peek_status(s);
    chk_cnt++;
    if (started || s !== exp_status(0, 0, 0, 1) || uart_tx_data_o !== 8'h11)
      $display("FAIL txflush_done: got start_seen=%b status=%h data=%h expected 0/%h/11",
               started, s, uart_tx_data_o, exp_status(0, 0, 0, 1));
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0]  q[$];
    bit          ovr = 0, ok, full_before;
    logic [31:0] s, d, exp_d;
    logic [7:0]  b;
    logic [2:0]  c;
    int          op, k;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 6);
      b  = 8'($urandom);
      case (op)
        0, 1, 2: begin
          inject_rx(b, ok);
          chk_cnt++; if (!ok) $display("FAIL rnd_clear%0d: handshake not seen", n); else pass_cnt++;
          if (q.size() < DEPTH) q.push_back(b); else ovr = 1;
        end
        3: begin
          exp_d = (q.size() != 0) ? 32'(q.pop_front()) : 32'h0;
          bus_read(1, d);
          chk_cnt++; if (d !== exp_d) $display("FAIL rnd_read%0d: got %h expected %h", n, d, exp_d); else pass_cnt++;
        end
        4: begin
          c = 3'($urandom);
          bus_write(3, 32'(c));
          if (c[1]) q.delete();
          if (c[2]) ovr = 0;
        end
        5: begin
          exp_d = (q.size() != 0) ? 32'(q[0]) : 32'h0;
          full_before = (q.size() == DEPTH);
          uart_rx_data_i = b; uart_rx_ready_i = 1;
          sel_i = 1; re_i = 1; addr_i = 2'd1;
          #1 d = rdata_o;
          @(posedge clk); #1;
          sel_i = 0; re_i = 0; uart_rx_ready_i = 0;
          @(posedge clk); #1;
          chk_cnt++; if (d !== exp_d) $display("FAIL rnd_popush%0d: got %h expected %h", n, d, exp_d); else pass_cnt++;
          if (q.size() != 0) void'(q.pop_front());
          if (!full_before) q.push_back(b); else ovr = 1;
        end
        default: begin
          bus_write(0, 32'(b));
          k = 0;
          while (!uart_tx_start_o && k < 5) begin @(posedge clk); #1; k++; end
          chk_cnt++;
          if (!uart_tx_start_o || uart_tx_data_o !== b)
            $display("FAIL rnd_tx%0d: got start=%b data=%h expected 1/%h", n, uart_tx_start_o, uart_tx_data_o, b);
          else pass_cnt++;
          uart_tx_busy_i = 1;
          cycles(1);
          uart_tx_busy_i = 0;
          cycles(2);
        end
      endcase
      peek_status(s);
      chk_cnt++;
      if (s !== exp_status(0, q.size(), ovr, 1))
        $display("FAIL rnd_status%0d: got %h expected %h", n, s, exp_status(0, q.size(), ovr, 1));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    uart_tx_busy_i = 1;
    bus_write(0, 32'h77);
    bus_write(0, 32'h78);
    uart_rx_data_i = 8'h99; uart_rx_ready_i = 1;
    cycles(1);
    reset = 1;
    cycles(1);
    uart_rx_ready_i = 0; uart_tx_busy_i = 0;
    chk_cnt++;
    if (uart_tx_start_o !== 1'b0 || uart_tx_data_o !== 8'h00 || uart_clear_rx_o !== 1'b0)
      $display("FAIL midreset_outputs: got start=%b data=%h clear=%b expected 0/00/0",
               uart_tx_start_o, uart_tx_data_o, uart_clear_rx_o);
    else pass_cnt++;
    reset = 0;
    cycles(2);
    peek_status(s);
    chk_cnt++; if (s !== 32'h8 || uart_tx_start_o !== 1'b0) $display("FAIL midreset_status: got %h start=%b expected 00000008 start=0", s, uart_tx_start_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tx_pair();
    test_tx_full();
    test_rx_single();
    test_rx_overrun();
    test_back_to_back_rx();
    test_tx_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
